// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
// Collects a frame of N_OPS operand words followed by one opcode word from a
// first-word-fall-through RX FIFO, presents them to an external ALU, samples
// the ALU result after ALU_LAT cycles and pushes it into the TX FIFO.
// A frame that stalls for TIMEOUT cycles between words is abandoned.
//
// Ports
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_rx_empty         RX FIFO empty; i_r_data valid while low
//   i_r_data           RX FIFO head word
//   i_tx_full          TX FIFO full
//   i_result_data      ALU result
//   o_rd_uart          RX pop strobe (combinational, one per consumed word)
//   o_wr_uart          TX push strobe, one cycle
//   o_w_data           last sampled ALU result
//   o_operands         operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_op_code          ALU opcode
//   o_busy             high whenever the FSM is not in IDLE
//   o_timeout          one-cycle pulse when a frame is aborted
module uart_alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int N_OPS      = 2,
  parameter int OPCODE_SZ  = 6,
  parameter int ALU_LAT    = 1,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_rx_empty,
  input  logic [DATA_WIDTH-1:0]       i_r_data,
  input  logic                        i_tx_full,
  input  logic [DATA_WIDTH-1:0]       i_result_data,
  output logic                        o_rd_uart,
  output logic                        o_wr_uart,
  output logic [DATA_WIDTH-1:0]       o_w_data,
  output logic [N_OPS*DATA_WIDTH-1:0] o_operands,
  output logic [OPCODE_SZ-1:0]        o_op_code,
  output logic                        o_busy,
  output logic                        o_timeout
);

  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  // The abort fires on the edge that would take the counter to TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [3:0]      LAST_IDX = 4'(N_OPS - 1);
  localparam logic [3:0]      LAT_END  = 4'(ALU_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OPER  = 3'd1,
    RX_OPC   = 3'd2,
    WAIT_ALU = 3'd3,
    SEND     = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [3:0]      idx_r;
  logic [3:0]      lat_cnt_r;
  logic [TO_W-1:0] to_cnt_r;

  logic       rd_s;
  logic       wr_s;
  logic       cap_oper_s;
  logic       cap_opc_s;
  logic       sample_s;
  logic       rx_wait_s;
  logic       to_fire_s;
  logic [3:0] oper_idx_s;

  assign o_rd_uart = rd_s & ~i_reset;
  assign o_wr_uart = wr_s;
  assign o_busy    = (state != IDLE);

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    rd_s       = 1'b0;
    wr_s       = 1'b0;
    cap_oper_s = 1'b0;
    cap_opc_s  = 1'b0;
    sample_s   = 1'b0;
    rx_wait_s  = 1'b0;
    to_fire_s  = 1'b0;
    oper_idx_s = idx_r;
    case (state)
      IDLE: begin
        // A new frame always starts at operand 0, whatever idx_r holds.
        oper_idx_s = 4'd0;
        if (!i_rx_empty) begin
          rd_s       = 1'b1;
          cap_oper_s = 1'b1;
          state_next = (N_OPS == 1) ? RX_OPC : RX_OPER;
        end else begin
          state_next = IDLE;
        end
      end
      RX_OPER: begin
        if (!i_rx_empty) begin
          rd_s       = 1'b1;
          cap_oper_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_next = RX_OPC;
          end else begin
            state_next = RX_OPER;
          end
        end else begin
          rx_wait_s = 1'b1;
          if (to_cnt_r == TO_LAST) begin
            to_fire_s  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RX_OPER;
          end
        end
      end
      RX_OPC: begin
        if (!i_rx_empty) begin
          rd_s       = 1'b1;
          cap_opc_s  = 1'b1;
          state_next = WAIT_ALU;
        end else begin
          rx_wait_s = 1'b1;
          if (to_cnt_r == TO_LAST) begin
            to_fire_s  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RX_OPC;
          end
        end
      end
      WAIT_ALU: begin
        if (lat_cnt_r == LAT_END) begin
          sample_s   = 1'b1;
          state_next = SEND;
        end else begin
          state_next = WAIT_ALU;
        end
      end
      SEND: begin
        if (!i_tx_full) begin
          wr_s       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = SEND;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame datapath: operands, opcode, result and the three counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idx_r      <= 4'd0;
      lat_cnt_r  <= 4'd0;
      to_cnt_r   <= '0;
      o_operands <= '0;
      o_op_code  <= '0;
      o_w_data   <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_timeout <= to_fire_s;

      if (cap_oper_s) begin
        o_operands[oper_idx_s*DATA_WIDTH +: DATA_WIDTH] <= i_r_data;
        idx_r <= oper_idx_s + 4'd1;
      end else if (cap_opc_s || to_fire_s) begin
        idx_r <= 4'd0;
      end

      if (cap_opc_s) begin
        o_op_code <= i_r_data[OPCODE_SZ-1:0];
      end

      if (cap_opc_s) begin
        lat_cnt_r <= 4'd0;
      end else if (state == WAIT_ALU) begin
        lat_cnt_r <= lat_cnt_r + 4'd1;
      end

      if (sample_s) begin
        o_w_data <= i_result_data;
      end

      // Counts only idle gaps inside a frame; any pop restarts it.
      if (rd_s || to_fire_s) begin
        to_cnt_r <= '0;
      end else if (rx_wait_s) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer. A two-operand instance (ALU_LAT=1,
// TIMEOUT=16) covers the main frame, TX backpressure, timeout, queued frames
// and mid-frame reset; a four-operand instance (ALU_LAT=0) covers
// back-to-back reception and zero ALU latency. RX FIFOs are modelled with
// queues; TX pushes are logged into queues.
module tb_uart_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rx_empty, tx_full, rd_uart, wr_uart, busy, timeout;
  logic [7:0]  r_data, result_data, w_data;
  logic [15:0] operands;
  logic [5:0]  op_code;

  logic        rx_empty4, rd_uart4, wr_uart4, busy4, timeout4;
  logic [7:0]  r_data4, result_data4, w_data4;
  logic [31:0] operands4;
  logic [5:0]  op_code4;

  logic [7:0] rxq[$];
  logic [7:0] rx4q[$];
  logic [7:0] txq[$];
  logic [7:0] tx4q[$];
  int         pops, pops4, to_pulses;
  logic       pop_now, pop4_now;

  int tests_run    = 0;
  int tests_failed = 0;

  // ALU model: sum of the two operands; constant for the wide instance.
  assign result_data  = operands[7:0] + operands[15:8];
  assign result_data4 = 8'hA5;

  uart_alu_sequencer #(
    .DATA_WIDTH(8), .N_OPS(2), .OPCODE_SZ(6), .ALU_LAT(1), .TIMEOUT(16)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_empty(rx_empty), .i_r_data(r_data),
    .i_tx_full(tx_full), .i_result_data(result_data), .o_rd_uart(rd_uart),
    .o_wr_uart(wr_uart), .o_w_data(w_data), .o_operands(operands),
    .o_op_code(op_code), .o_busy(busy), .o_timeout(timeout)
  );

  uart_alu_sequencer #(
    .DATA_WIDTH(8), .N_OPS(4), .OPCODE_SZ(6), .ALU_LAT(0), .TIMEOUT(16)
  ) dut4 (
    .i_clk(clk), .i_reset(reset), .i_rx_empty(rx_empty4), .i_r_data(r_data4),
    .i_tx_full(1'b0), .i_result_data(result_data4), .o_rd_uart(rd_uart4),
    .o_wr_uart(wr_uart4), .o_w_data(w_data4), .o_operands(operands4),
    .o_op_code(op_code4), .o_busy(busy4), .o_timeout(timeout4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_empty  = (rxq.size() == 0);
    r_data    = (rxq.size() != 0) ? rxq[0] : 8'h00;
    rx_empty4 = (rx4q.size() == 0);
    r_data4   = (rx4q.size() != 0) ? rx4q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    refresh_rx();
  endtask

  // Waits for the TX log to reach n entries; returns negedges taken.
  task automatic wait_tx(input string tag, input int n, output int k);
    k = 0;
    while (txq.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(tag, txq.size(), n);
  endtask

  // FIFO side: strobes seen at the edge are applied just after it.
  always @(posedge clk) begin
    pop_now  = rd_uart;
    pop4_now = rd_uart4;
    if (wr_uart)  txq.push_back(w_data);
    if (wr_uart4) tx4q.push_back(w_data4);
    #1;
    if (pop_now) begin
      void'(rxq.pop_front());
      pops++;
    end
    if (pop4_now) begin
      void'(rx4q.pop_front());
      pops4++;
    end
    refresh_rx();
  end

  always @(negedge clk) begin
    if (timeout) to_pulses++;
  end

  initial begin
    int k, base, p0, t0;
    pops = 0; pops4 = 0; to_pulses = 0;
    reset   = 1'b1;
    tx_full = 1'b0;
    refresh_rx();

    // Reset state, with a frame already waiting in the RX FIFO.
    repeat (2) @(negedge clk);
    push(8'h05); push(8'h03); push(8'h20);
    #1;
    check("rst_rd_uart", rd_uart, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_operands", operands, 16'h0000);
    check("rst_op_code", op_code, 6'h00);
    check("rst_w_data", w_data, 8'h00);
    check("rst_wr_uart", wr_uart, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    // Basic frame: 5 + 3, opcode 0x20. 3 rx + 2 wait + 1 send cycles.
    @(negedge clk);
    reset = 1'b0;
    wait_tx("f1_wait", 1, k);
    check("f1_latency", k, 6);
    check("f1_result", txq[0], 8'h08);
    check("f1_pops", pops, 3);
    check("f1_operands", operands, 16'h0305);
    check("f1_op_code", op_code, 6'h20);
    @(negedge clk);
    check("f1_idle", busy, 1'b0);

    // TX backpressure: frame 0x10 + 0x07 reaches SEND 5 edges after push.
    base = txq.size();
    tx_full = 1'b1;
    push(8'h10); push(8'h07); push(8'h01);
    repeat (5) @(negedge clk);
    repeat (10) @(negedge clk);
    check("bp_no_write", txq.size(), base);
    check("bp_busy", busy, 1'b1);
    tx_full = 1'b0;
    @(negedge clk);
    check("bp_one_write", txq.size(), base + 1);
    check("bp_result", txq[base], 8'h17);
    check("bp_idle", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("bp_single", txq.size(), base + 1);

    // Timeout: one operand then silence. Pop on the edge after the push,
    // pulse visible 16 edges later, i.e. at the 17th negedge.
    base = txq.size();
    t0 = to_pulses;
    push(8'h09);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timeout && k < 40);
    check("to_delay", k, 17);
    @(negedge clk);
    check("to_idle", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("to_once", to_pulses - t0, 1);
    check("to_partial", operands, 16'h0709);
    check("to_no_write", txq.size(), base);
    push(8'h21); push(8'h02); push(8'h05);
    wait_tx("to_next_wait", base + 1, k);
    check("to_next_result", txq[base], 8'h23);
    check("to_next_operands", operands, 16'h0221);

    // Two frames queued: no pops while in WAIT_ALU/SEND.
    @(negedge clk);
    base = txq.size();
    p0 = pops;
    push(8'h01); push(8'h02); push(8'h00);
    push(8'h0A); push(8'h0B); push(8'h3F);
    repeat (3) @(negedge clk);
    check("q_first_pops", pops - p0, 3);
    repeat (3) @(negedge clk);
    check("q_hold_pops", pops - p0, 3);
    wait_tx("q_wait", base + 2, k);
    check("q_result_a", txq[base], 8'h03);
    check("q_result_b", txq[base+1], 8'h15);
    check("q_pops", pops - p0, 6);
    check("q_op_code", op_code, 6'h3F);

    // Reset after the second operand.
    @(negedge clk);
    base = txq.size();
    push(8'h55); push(8'h66);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr_operands", operands, 16'h0000);
    check("mr_op_code", op_code, 6'h00);
    check("mr_w_data", w_data, 8'h00);
    check("mr_busy", busy, 1'b0);
    push(8'h04); push(8'h06); push(8'h11);
    @(negedge clk);
    reset = 1'b0;
    wait_tx("mr_wait", base + 1, k);
    check("mr_result", txq[base], 8'h0A);
    check("mr_new_operands", operands, 16'h0604);
    check("mr_new_op_code", op_code, 6'h11);

    // Four operands back-to-back, ALU_LAT=0: 5 pops, 1 wait, 1 send.
    @(negedge clk);
    rx4q.push_back(8'h11); rx4q.push_back(8'h22); rx4q.push_back(8'h33);
    rx4q.push_back(8'h44); rx4q.push_back(8'h3F);
    refresh_rx();
    repeat (4) @(negedge clk);
    check("w4_pops4", pops4, 4);
    @(negedge clk);
    check("w4_pops5", pops4, 5);
    @(negedge clk);
    check("w4_no_write_yet", tx4q.size(), 0);
    @(negedge clk);
    check("w4_write", tx4q.size(), 1);
    check("w4_result", (tx4q.size() != 0) ? tx4q[0] : 8'h00, 8'hA5);
    check("w4_operands", operands4, 32'h44332211);
    check("w4_op_code", op_code4, 6'h3F);
    check("w4_idle", busy4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: UART word and operand width.
REQ-002 Parameter N_OPS, default 2: operands per frame; legal range 1..8.
REQ-003 Parameter OPCODE_SZ, default 6: opcode width; must be <= DATA_WIDTH.
REQ-004 Parameter ALU_LAT, default 1: cycles from opcode capture to result sample; legal range 0..15.
REQ-005 Parameter TIMEOUT, default 1000000: idle clock cycles allowed between bytes inside a frame; must be >= 1.
REQ-006 i_clk  in  1  clock; all state updates on the rising edge.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_rx_empty  in  1  RX FIFO empty; i_r_data is valid whenever this is low (first-word-fall-through).
REQ-009 i_r_data  in  DATA_WIDTH  RX FIFO head word.
REQ-010 i_tx_full  in  1  TX FIFO full.
REQ-011 i_result_data  in  DATA_WIDTH  ALU result.
REQ-012 o_rd_uart  out  1  RX FIFO pop strobe, one per consumed word.
REQ-013 o_wr_uart  out  1  TX FIFO push strobe, one cycle wide.
REQ-014 o_w_data  out  DATA_WIDTH  word pushed to the TX FIFO.
REQ-015 o_operands  out  N_OPS*DATA_WIDTH  operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 o_op_code  out  OPCODE_SZ  ALU opcode.
REQ-017 o_busy  out  1  high in any state other than IDLE.
REQ-018 o_timeout  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-019 Frame format: N_OPS operand words, operand 0 first, then one opcode word; the opcode is i_r_data[OPCODE_SZ-1:0] and the upper bits are ignored.
REQ-020 States: IDLE, RX_OPER, RX_OPC, WAIT_ALU, SEND.
REQ-021 o_rd_uart shall be combinational: it equals (state is IDLE, RX_OPER or RX_OPC) AND ~i_rx_empty; the word is captured on the same edge.
REQ-022 IDLE with ~i_rx_empty: pop the word, store it as operand 0, set the operand index to 1, then go to RX_OPC if N_OPS==1, otherwise to RX_OPER.
REQ-023 RX_OPER with ~i_rx_empty: pop the word and store it at the current index, then increment the index; after storing index N_OPS-1, go to RX_OPC.
REQ-024 RX_OPC with ~i_rx_empty: pop the word, latch the opcode, clear the latency counter and go to WAIT_ALU.
REQ-025 Outputs o_operands and o_op_code update only at their capture edge and hold at all other times, including after the frame completes.
REQ-026 WAIT_ALU: the counter increments each cycle; when the counter equals ALU_LAT, sample i_result_data into the result register and go to SEND; with ALU_LAT=0 this happens on the first WAIT_ALU cycle.
REQ-027 SEND: while i_tx_full is high, hold and keep o_wr_uart low; on the first cycle with ~i_tx_full, assert o_wr_uart for exactly one cycle with o_w_data equal to the result register, then return to IDLE.
REQ-028 o_w_data holds the last sampled result between frames.
REQ-029 Timeout counter: cleared on every pop; incremented each cycle in RX_OPER or RX_OPC while i_rx_empty is high.
REQ-030 When the timeout counter reaches TIMEOUT: go to IDLE, pulse o_timeout, clear the operand index, and leave the partial operands unchanged.
REQ-031 Timeout never applies in IDLE, WAIT_ALU or SEND, and no TX write occurs for an aborted frame.
REQ-032 Words arriving during WAIT_ALU or SEND stay in the RX FIFO and are not popped; reading resumes in IDLE.
REQ-033 Back-to-back frames are supported: a word waiting in IDLE is popped in the first IDLE cycle.
REQ-034 The block sustains one word per cycle.
REQ-035 Throughput with ALU_LAT=L and no TX backpressure is N_OPS+1 receive cycles, plus L+1 WAIT_ALU cycles, plus 1 SEND cycle.
REQ-036 An unreachable state encoding returns the FSM to IDLE.

Reset
REQ-037 While i_reset is high: state is IDLE, and all counters, operands, opcode, result, o_w_data, o_wr_uart and o_timeout are 0.
REQ-038 o_rd_uart is 0 while i_reset is high.
REQ-039 Reset asserted mid-frame discards the frame; the first word popped after reset is treated as operand 0.

Verification
REQ-040 Scenario: N_OPS=2, ALU_LAT=1, RX words 0x05, 0x03, 0x20, result driven = a+b -> o_operands=0x0305, o_op_code=0x20, one o_wr_uart pulse with o_w_data=0x08, exactly 3 pops.
REQ-041 Scenario: N_OPS=4, words 0x11, 0x22, 0x33, 0x44, 0x3F delivered back-to-back -> 5 consecutive pop cycles, o_operands=0x44332211, o_op_code=0x3F.
REQ-042 Scenario: i_tx_full held high for 10 cycles in SEND -> no o_wr_uart during those cycles, then a single pulse on the first cycle after release, then IDLE.
REQ-043 Scenario: TIMEOUT=16, one operand sent then RX stays empty -> o_timeout pulses once, 16 cycles after the pop, state returns to IDLE, and a following full frame computes correctly.
REQ-044 Scenario: a second frame is queued in the RX FIFO during WAIT_ALU and SEND -> no pops until IDLE, then both results are transmitted in order.
REQ-045 Scenario: i_reset pulsed after the second operand -> all outputs are 0, and the next 3 words form a fresh frame.
